uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Command-frame responder between the uart FIFOs and a 16-bit register bus.
// Define UART_CMD_ERRCNT_EN to add the saturating err_cnt output.
module uart_cmd_responder #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [7:0]  SYNC_RX     = 8'hA5,
    parameter logic [7:0]  SYNC_TX     = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rx_fifo_ren,
    input  logic [7:0]  rx_fifo_rdata,
    input  logic        rx_fifo_empty,
    output logic        tx_fifo_wen,
    output logic [7:0]  tx_fifo_wdata,
    input  logic        tx_fifo_full,
    output logic        reg_wen,
    output logic        reg_ren,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        busy,
`ifdef UART_CMD_ERRCNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        frame_err
);

    localparam logic [7:0] CMD_WR     = 8'h01;
    localparam logic [7:0] CMD_RD     = 8'h02;
    localparam logic [7:0] STS_OK     = 8'h00;
    localparam logic [7:0] STS_BADCHK = 8'h01;
    localparam logic [7:0] STS_BADCMD = 8'h02;

    typedef enum logic [3:0] {
        ST_SYNC   = 4'd0,
        ST_CMD    = 4'd1,
        ST_ADDR   = 4'd2,
        ST_DH     = 4'd3,
        ST_DL     = 4'd4,
        ST_CHK    = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RDWAIT = 4'd7,
        ST_RESP   = 4'd8
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        run_r, rd_vld_r;
    logic [7:0]  cmd_r, chk_r, status_r;
    logic        need_data_r, chk_ok_r, rd_cap_r;
    logic [15:0] rdata_r, tmo_cnt_r;
    logic [2:0]  tx_idx_r;
    logic        fetch_st_s, tmo_st_s, tmo_fire_s, rd_reply_s, tx_last_s;
    logic [7:0]  status_s, tx_chk_s, tx_byte_s;
    logic [2:0]  tx_len_s;
    logic        reg_wen_nxt_s, reg_ren_nxt_s, frame_err_nxt_s, busy_nxt_s;

    function automatic logic [7:0] reply_chk(input logic [7:0] cmd, input logic [7:0] addr,
                                             input logic [7:0] status, input logic [15:0] data,
                                             input logic with_data);
        logic [7:0] x;
        x = cmd ^ addr ^ status;
        if (with_data) x = x ^ data[15:8] ^ data[7:0];
        else           x = x;
        return x;
    endfunction

    // State classification, execution status and reply byte selection
    always_comb begin
        fetch_st_s = 1'b0;
        tmo_st_s   = 1'b0;
        case (state_r)
            ST_SYNC:                          fetch_st_s = 1'b1;
            ST_CMD, ST_ADDR, ST_DH, ST_DL, ST_CHK: begin
                fetch_st_s = 1'b1;
                tmo_st_s   = 1'b1;
            end
            default: begin
                fetch_st_s = 1'b0;
                tmo_st_s   = 1'b0;
            end
        endcase
        tmo_fire_s = tmo_st_s && !rd_vld_r && (tmo_cnt_r == TIMEOUT_CYC - 16'd1);
        if (!chk_ok_r)                                 status_s = STS_BADCHK;
        else if ((cmd_r == CMD_WR) || (cmd_r == CMD_RD)) status_s = STS_OK;
        else                                           status_s = STS_BADCMD;
        rd_reply_s = (status_r == STS_OK) && (cmd_r == CMD_RD);
        tx_len_s   = rd_reply_s ? 3'd7 : 3'd5;
        tx_last_s  = (tx_idx_r == tx_len_s - 3'd1);
        tx_chk_s   = reply_chk(cmd_r, reg_addr, status_r, rdata_r, rd_reply_s);
        case (tx_idx_r)
            3'd0:    tx_byte_s = SYNC_TX;
            3'd1:    tx_byte_s = cmd_r;
            3'd2:    tx_byte_s = reg_addr;
            3'd3:    tx_byte_s = status_r;
            3'd4:    tx_byte_s = rd_reply_s ? rdata_r[15:8] : tx_chk_s;
            3'd5:    tx_byte_s = rdata_r[7:0];
            3'd6:    tx_byte_s = tx_chk_s;
            default: tx_byte_s = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_SYNC;
        else     state_r <= state_nxt_s;
    end

    // Next-state logic; a timeout abandons the frame with no reply
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SYNC:   if (rd_vld_r && (rx_fifo_rdata == SYNC_RX)) state_nxt_s = ST_CMD;
                       else state_nxt_s = ST_SYNC;
            ST_CMD:    if (tmo_fire_s) state_nxt_s = ST_SYNC;
                       else if (rd_vld_r) state_nxt_s = ST_ADDR;
                       else state_nxt_s = ST_CMD;
            ST_ADDR:   if (tmo_fire_s) state_nxt_s = ST_SYNC;
                       else if (rd_vld_r) state_nxt_s = need_data_r ? ST_DH : ST_CHK;
                       else state_nxt_s = ST_ADDR;
            ST_DH:     if (tmo_fire_s) state_nxt_s = ST_SYNC;
                       else if (rd_vld_r) state_nxt_s = ST_DL;
                       else state_nxt_s = ST_DH;
            ST_DL:     if (tmo_fire_s) state_nxt_s = ST_SYNC;
                       else if (rd_vld_r) state_nxt_s = ST_CHK;
                       else state_nxt_s = ST_DL;
            ST_CHK:    if (tmo_fire_s) state_nxt_s = ST_SYNC;
                       else if (rd_vld_r) state_nxt_s = ST_EXEC;
                       else state_nxt_s = ST_CHK;
            ST_EXEC:   if ((status_s == STS_OK) && (cmd_r == CMD_RD)) state_nxt_s = ST_RDWAIT;
                       else state_nxt_s = ST_RESP;
            ST_RDWAIT: state_nxt_s = ST_RESP;
            ST_RESP:   if (tx_fifo_wen && tx_last_s) state_nxt_s = ST_SYNC;
                       else state_nxt_s = ST_RESP;
            default:   state_nxt_s = ST_SYNC;
        endcase
    end

    // Output decode; FIFO strobes stay combinational so they track empty/full exactly
    always_comb begin
        reg_wen_nxt_s   = 1'b0;
        reg_ren_nxt_s   = 1'b0;
        frame_err_nxt_s = 1'b0;
        if (state_r == ST_EXEC) begin
            reg_wen_nxt_s   = (status_s == STS_OK) && (cmd_r == CMD_WR);
            reg_ren_nxt_s   = (status_s == STS_OK) && (cmd_r == CMD_RD);
            frame_err_nxt_s = (status_s != STS_OK);
        end else begin
            frame_err_nxt_s = tmo_fire_s;
        end
        busy_nxt_s  = (state_nxt_s != ST_SYNC);
        rx_fifo_ren = run_r && fetch_st_s && !rx_fifo_empty && !rd_vld_r && !tmo_fire_s;
        if ((state_r == ST_RESP) && !tx_fifo_full) begin
            tx_fifo_wen   = 1'b1;
            tx_fifo_wdata = tx_byte_s;
        end else begin
            tx_fifo_wen   = 1'b0;
            tx_fifo_wdata = 8'h00;
        end
    end

    // Registered bus strobes and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wen   <= 1'b0;
            reg_ren   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            run_r     <= 1'b0;
            rd_vld_r  <= 1'b0;
        end else begin
            reg_wen   <= reg_wen_nxt_s;
            reg_ren   <= reg_ren_nxt_s;
            frame_err <= frame_err_nxt_s;
            busy      <= busy_nxt_s;
            run_r     <= 1'b1;
            rd_vld_r  <= rx_fifo_ren;
        end
    end

    // Frame field capture, running checksum and reply byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r       <= 8'h00;
            chk_r       <= 8'h00;
            need_data_r <= 1'b0;
            chk_ok_r    <= 1'b0;
            reg_addr    <= 8'h00;
            reg_wdata   <= 16'h0000;
            status_r    <= 8'h00;
            tx_idx_r    <= 3'd0;
        end else begin
            case (state_r)
                ST_CMD: if (rd_vld_r) begin
                    cmd_r       <= rx_fifo_rdata;
                    chk_r       <= rx_fifo_rdata;
                    need_data_r <= (rx_fifo_rdata == CMD_WR);
                end
                ST_ADDR: if (rd_vld_r) begin
                    reg_addr <= rx_fifo_rdata;
                    chk_r    <= chk_r ^ rx_fifo_rdata;
                end
                ST_DH: if (rd_vld_r) begin
                    reg_wdata[15:8] <= rx_fifo_rdata;
                    chk_r           <= chk_r ^ rx_fifo_rdata;
                end
                ST_DL: if (rd_vld_r) begin
                    reg_wdata[7:0] <= rx_fifo_rdata;
                    chk_r          <= chk_r ^ rx_fifo_rdata;
                end
                ST_CHK:  if (rd_vld_r) chk_ok_r <= (rx_fifo_rdata == chk_r);
                ST_EXEC: begin
                    status_r <= status_s;
                    tx_idx_r <= 3'd0;
                end
                ST_RESP: if (tx_fifo_wen) tx_idx_r <= tx_idx_r + 3'd1;
                default: tx_idx_r <= tx_idx_r;
            endcase
        end
    end

    // reg_rdata is valid the cycle after reg_ren; capture it then
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cap_r <= 1'b0;
            rdata_r  <= 16'h0000;
        end else begin
            rd_cap_r <= reg_ren;
            if (rd_cap_r) rdata_r <= reg_rdata;
        end
    end

    // Inter-byte timeout counter, live only while a frame is being received
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       tmo_cnt_r <= 16'd0;
        else if (!tmo_st_s || rd_vld_r) tmo_cnt_r <= 16'd0;
        else                           tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end

`ifdef UART_CMD_ERRCNT_EN
    // Saturating error counter, cleared by a successful write to address FF
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        err_cnt <= 8'h00;
        else if (reg_wen_nxt_s && (reg_addr == 8'hFF))  err_cnt <= 8'h00;
        else if (frame_err_nxt_s && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'h01;
        else                                            err_cnt <= err_cnt;
    end
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: directed frames in, expected
// bus operations and reply bytes queued, a negedge monitor pops and compares.
module tb_uart_cmd_responder;
    localparam logic [15:0] TMO = 16'd300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_fifo_ren;
    logic [7:0]  rx_fifo_rdata = 8'h00;
    logic        rx_fifo_empty = 1'b1;
    logic        tx_fifo_wen;
    logic [7:0]  tx_fifo_wdata;
    logic        tx_fifo_full = 1'b0;
    logic        reg_wen, reg_ren;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0000;
    logic        busy, frame_err;
`ifdef UART_CMD_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_exp = 0;
    int full_viol = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic        exp_rk[$];
    logic [7:0]  exp_ra[$];
    logic [15:0] exp_rd[$];
    logic [15:0] regmem [256];

    uart_cmd_responder #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_fifo_ren(rx_fifo_ren), .rx_fifo_rdata(rx_fifo_rdata), .rx_fifo_empty(rx_fifo_empty),
        .tx_fifo_wen(tx_fifo_wen), .tx_fifo_wdata(tx_fifo_wdata), .tx_fifo_full(tx_fifo_full),
        .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy),
`ifdef UART_CMD_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // rx FIFO with one-cycle read latency, and a simple register-file slave
    always @(posedge clk) begin
        if (rx_fifo_ren && rx_q.size() != 0) rx_fifo_rdata <= rx_q.pop_front();
        rx_fifo_empty <= (rx_q.size() == 0);
        if (reg_wen) regmem[reg_addr] <= reg_wdata;
        if (reg_ren) reg_rdata <= regmem[reg_addr];
    end

    // Monitor: compare every DUT transaction against the scoreboard queues
    always @(negedge clk) begin : mon
        logic [7:0]  eb;
        logic        ek;
        logic [7:0]  ea;
        logic [15:0] ed;
        if (!rst) begin
            if (tx_fifo_wen) begin
                if (tx_fifo_full) begin
                    full_viol++;
                    $display("FAIL tx_wen_while_full: wen=1 full=1 at %0t", $time);
                end
                total++;
                if (exp_tx.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got %h want none", tx_fifo_wdata);
                end else begin
                    eb = exp_tx.pop_front();
                    if (tx_fifo_wdata !== eb) begin
                        bad++;
                        $display("FAIL tx_byte: got %h want %h", tx_fifo_wdata, eb);
                    end
                end
            end
            if (reg_wen || reg_ren) begin
                total++;
                if (exp_ra.size() == 0) begin
                    bad++;
                    $display("FAIL reg_unexpected: wen=%b ren=%b addr=%h want none", reg_wen, reg_ren, reg_addr);
                end else begin
                    ek = exp_rk.pop_front();
                    ea = exp_ra.pop_front();
                    ed = exp_rd.pop_front();
                    if ((reg_wen !== ek) || (reg_ren !== !ek) || (reg_addr !== ea) || (ek && (reg_wdata !== ed))) begin
                        bad++;
                        $display("FAIL reg_op: got wen=%b ren=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                                 reg_wen, reg_ren, reg_addr, reg_wdata, ek, ea, ed);
                    end
                end
            end
            if (frame_err) err_seen++;
            if (rx_fifo_ren && rx_fifo_empty) begin
                bad++;
                $display("FAIL rx_ren_when_empty: ren=1 empty=1 at %0t", $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rxb(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic txb(input logic [7:0] b);
        exp_tx.push_back(b);
    endtask

    task automatic exp_reg(input logic w, input logic [7:0] a, input logic [15:0] d);
        exp_rk.push_back(w);
        exp_ra.push_back(a);
        exp_rd.push_back(d);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_ra.size() != 0 || rx_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({nm, "_done_in_time"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
        chk({nm, "_frame_err_count"}, err_seen, err_exp);
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_strobes"}, {26'd0, rx_fifo_ren, tx_fifo_wen, reg_wen, reg_ren, frame_err, 1'b0}, 32'd0);
        chk({nm, "_addr_wdata"}, {reg_addr, reg_wdata, tx_fifo_wdata}, 32'd0);
    endtask

    task automatic bad_frame();
        rxb(8'hA5); rxb(8'h07); rxb(8'h10); rxb(8'h17);
        txb(8'h5A); txb(8'h07); txb(8'h10); txb(8'h02); txb(8'h15);
        err_exp++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) regmem[i] = 16'h0000;
        regmem[8'h20] = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 rst = 1'b0;

        // write 0x1234 to 0x10
        rxb(8'hA5); rxb(8'h01); rxb(8'h10); rxb(8'h12); rxb(8'h34); rxb(8'h37);
        exp_reg(1'b1, 8'h10, 16'h1234);
        txb(8'h5A); txb(8'h01); txb(8'h10); txb(8'h00); txb(8'h11);
        wait_idle("write10");

        // read 0x20 and 0x10
        rxb(8'hA5); rxb(8'h02); rxb(8'h20); rxb(8'h22);
        exp_reg(1'b0, 8'h20, 16'h0000);
        txb(8'h5A); txb(8'h02); txb(8'h20); txb(8'h00); txb(8'hBE); txb(8'hEF); txb(8'h73);
        wait_idle("read20");
        rxb(8'hA5); rxb(8'h02); rxb(8'h10); rxb(8'h12);
        exp_reg(1'b0, 8'h10, 16'h0000);
        txb(8'h5A); txb(8'h02); txb(8'h10); txb(8'h00); txb(8'h12); txb(8'h34); txb(8'h34);
        wait_idle("read10");

        // bad checksum, then unknown command
        rxb(8'hA5); rxb(8'h01); rxb(8'h10); rxb(8'h12); rxb(8'h34); rxb(8'h00);
        txb(8'h5A); txb(8'h01); txb(8'h10); txb(8'h01); txb(8'h10);
        err_exp++;
        wait_idle("badchk");
        bad_frame();
        wait_idle("badcmd");

        // garbage before a valid read
        rxb(8'h00); rxb(8'hFF); rxb(8'h5A);
        rxb(8'hA5); rxb(8'h02); rxb(8'h20); rxb(8'h22);
        exp_reg(1'b0, 8'h20, 16'h0000);
        txb(8'h5A); txb(8'h02); txb(8'h20); txb(8'h00); txb(8'hBE); txb(8'hEF); txb(8'h73);
        wait_idle("garbage");

        // timeout mid-frame, then normal service
        rxb(8'hA5); rxb(8'h01);
        repeat (int'(TMO) + 10) @(negedge clk);
        err_exp++;
        chk("timeout_frame_err", err_seen, err_exp);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        rxb(8'hA5); rxb(8'h01); rxb(8'h30); rxb(8'hAB); rxb(8'hCD); rxb(8'h57);
        exp_reg(1'b1, 8'h30, 16'hABCD);
        txb(8'h5A); txb(8'h01); txb(8'h30); txb(8'h00); txb(8'h31);
        wait_idle("after_timeout_wr");
        rxb(8'hA5); rxb(8'h02); rxb(8'h30); rxb(8'h32);
        exp_reg(1'b0, 8'h30, 16'h0000);
        txb(8'h5A); txb(8'h02); txb(8'h30); txb(8'h00); txb(8'hAB); txb(8'hCD); txb(8'h54);
        wait_idle("after_timeout_rd");

        // tx FIFO full stall across a read reply
        @(posedge clk); #1 tx_fifo_full = 1'b1;
        rxb(8'hA5); rxb(8'h02); rxb(8'h20); rxb(8'h22);
        exp_reg(1'b0, 8'h20, 16'h0000);
        txb(8'h5A); txb(8'h02); txb(8'h20); txb(8'h00); txb(8'hBE); txb(8'hEF); txb(8'h73);
        repeat (100) @(negedge clk);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_no_bytes", exp_tx.size(), 32'd7);
        @(posedge clk); #1 tx_fifo_full = 1'b0;
        wait_idle("stall_release");
        chk("no_write_while_full", full_viol, 32'd0);

        // reset during a stalled reply
        @(posedge clk); #1 tx_fifo_full = 1'b1;
        rxb(8'hA5); rxb(8'h02); rxb(8'h10); rxb(8'h12);
        exp_reg(1'b0, 8'h10, 16'h0000);
        repeat (30) @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        rxb(8'hA5); rxb(8'h01); rxb(8'h40); rxb(8'h00); rxb(8'h05); rxb(8'h44);
        exp_reg(1'b1, 8'h40, 16'h0005);
        txb(8'h5A); txb(8'h01); txb(8'h40); txb(8'h00); txb(8'h41);
        wait_idle("postrst_write");

`ifdef UART_CMD_ERRCNT_EN
        rxb(8'hA5); rxb(8'h01); rxb(8'hFF); rxb(8'h00); rxb(8'h00); rxb(8'hFE);
        exp_reg(1'b1, 8'hFF, 16'h0000);
        txb(8'h5A); txb(8'h01); txb(8'hFF); txb(8'h00); txb(8'hFE);
        wait_idle("errcnt_clr0");
        chk("errcnt_zero", {24'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) bad_frame();
        wait_idle("errcnt_three");
        chk("errcnt_3", {24'd0, err_cnt}, 32'd3);
        for (int i = 0; i < 300; i++) begin
            bad_frame();
            wait_idle("errcnt_sat_frame");
        end
        chk("errcnt_sat", {24'd0, err_cnt}, 32'h000000FF);
        rxb(8'hA5); rxb(8'h01); rxb(8'hFF); rxb(8'h00); rxb(8'h00); rxb(8'hFE);
        exp_reg(1'b1, 8'hFF, 16'h0000);
        txb(8'h5A); txb(8'h01); txb(8'hFF); txb(8'h00); txb(8'hFE);
        wait_idle("errcnt_clr1");
        chk("errcnt_cleared", {24'd0, err_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
